audio_serial_rx: RTL and testbench

// - Parametrised successor to the 2-ch ADC input path. Deserialises an I2S,

---
 rtl/audio_serial_rx.sv | 199 +++++++++++++++++++
 tb/tb_audio_serial_rx.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_serial_rx.sv
`default_nettype none
//==============================================================================
// Module   : audio_serial_rx
// Brief    : I2S / left-justified / TDM deserialiser, oversampled in sys_clk.
//            Optional per-channel peak meter: define AUDIO_RX_PEAK_METER_EN.
// Revision : 1.0 - initial release
//==============================================================================
module audio_serial_rx #(
  parameter int DATA_W   = 24,
  parameter int SLOT_W   = 32,
  parameter int NUM_CH   = 2,
  parameter int I2S_MODE = 0
) (
  input  logic                     sys_clk,
  input  logic                     resetn,
  input  logic                     bclk,
  input  logic                     sync,
  input  logic                     sdata,
  input  logic                     clr_status,
  output logic [NUM_CH*DATA_W-1:0] sample_data,
  output logic                     sample_valid,
  input  logic                     sample_ready,
  output logic                     overrun,
  output logic                     frame_err,
  output logic                     locked
`ifdef AUDIO_RX_PEAK_METER_EN
  ,
  input  logic                     peak_clr,
  output logic [NUM_CH*DATA_W-1:0] peak_level
`endif
);

  localparam int c_total   = NUM_CH * SLOT_W;
  localparam int c_lead    = (I2S_MODE != 0) ? 1 : 0;
  localparam int c_short   = NUM_CH * DATA_W + c_lead;
  localparam int c_last    = (NUM_CH - 1) * SLOT_W + DATA_W - 1 + c_lead;
  localparam int c_cnt_w   = $clog2(c_total + 2);
  localparam int c_timeout = 4 * SLOT_W * NUM_CH;
  localparam int c_idle_w  = $clog2(c_timeout + 1);
  localparam int c_fw      = NUM_CH * DATA_W;

  typedef enum logic [1:0] {
    S_HUNT = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  logic [2:0]          r_bclk_s;
  logic [1:0]          r_sync_s;
  logic [1:0]          r_sdata_s;
  logic                r_sync_prev;
  logic                r_sync_seen;
  state_t              r_state;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [c_idle_w-1:0] r_idle;
  logic [1:0]          r_good_cnt;
  logic [c_fw-1:0]     r_frame;

  logic                w_rise, w_sync, w_start, w_active, w_cap;
  logic                w_complete, w_short, w_timeout, w_load;
  logic [c_cnt_w-1:0]  w_cnt;
  logic [c_fw-1:0]     w_frame;
  int                  w_slot, w_bit;

  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      r_bclk_s  <= '0;
      r_sync_s  <= '0;
      r_sdata_s <= '0;
    end else begin
      r_bclk_s  <= {r_bclk_s[1:0], bclk};
      r_sync_s  <= {r_sync_s[0], sync};
      r_sdata_s <= {r_sdata_s[0], sdata};
    end
  end

  // A start needs a sync level seen on an earlier rise, so a level left over
  // from reset is never mistaken for an edge.
  assign w_rise     = r_bclk_s[1] & ~r_bclk_s[2];
  assign w_sync     = r_sync_s[1];
  assign w_start    = w_rise & r_sync_seen &
                      ((I2S_MODE != 0) ? (r_sync_prev & ~w_sync) : (~r_sync_prev & w_sync));
  assign w_active   = w_start | (r_state != S_HUNT);
  assign w_cnt      = w_start ? '0 : r_cnt;
  assign w_short    = w_start & (r_state == S_RUN) & (r_cnt < c_cnt_w'(c_short));
  assign w_complete = w_rise & w_active & (w_cnt == c_cnt_w'(c_last));
  assign w_timeout  = ~w_rise & (r_idle == c_idle_w'(c_timeout - 1));
  assign w_load     = w_complete & (~sample_valid | sample_ready);

  always_comb begin
    w_slot  = int'(w_cnt) / SLOT_W;
    w_bit   = int'(w_cnt) % SLOT_W - c_lead;
    w_cap   = w_rise & w_active & (int'(w_cnt) < c_total) & (w_bit >= 0) & (w_bit < DATA_W);
    w_frame = r_frame;
    if (w_cap) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (ch == w_slot)
          w_frame[ch*DATA_W +: DATA_W] = {r_frame[ch*DATA_W +: DATA_W-1], r_sdata_s[1]};
      end
    end
  end

  // The completed word (including the bit arriving this cycle) is handed over
  // on the edge that enters DONE; DONE itself just re-arms for the next frame.
  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_HUNT;
      r_cnt        <= '0;
      r_idle       <= '0;
      r_good_cnt   <= '0;
      r_frame      <= '0;
      r_sync_prev  <= 1'b0;
      r_sync_seen  <= 1'b0;
      sample_data  <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      frame_err    <= 1'b0;
      locked       <= 1'b0;
    end else begin
      frame_err <= w_short;
      if (w_cap)
        r_frame <= w_frame;
      if (w_rise) begin
        r_sync_prev <= w_sync;
        r_sync_seen <= 1'b1;
        r_idle      <= '0;
      end else if (!w_timeout) begin
        r_idle <= r_idle + 1'b1;
      end
      if (w_rise && w_active)
        r_cnt <= (int'(w_cnt) < c_total) ? w_cnt + 1'b1 : w_cnt;

      case (r_state)
        S_HUNT:  if (w_start) r_state <= S_RUN;
        S_RUN:   if (w_complete) r_state <= S_DONE;
        default: r_state <= S_RUN;
      endcase

      if (clr_status)
        overrun <= 1'b0;
      if (w_load) begin
        sample_data  <= w_frame;
        sample_valid <= 1'b1;
      end else begin
        if (sample_valid && sample_ready)
          sample_valid <= 1'b0;
        if (w_complete)
          overrun <= 1'b1;
      end

      if (w_complete) begin
        if (r_good_cnt != 2'd0)
          locked <= 1'b1;
        if (r_good_cnt != 2'd2)
          r_good_cnt <= r_good_cnt + 2'd1;
      end
      if (w_short || w_timeout) begin
        locked     <= 1'b0;
        r_good_cnt <= 2'd0;
      end
      if (w_timeout)
        r_state <= S_HUNT;
    end
  end

`ifdef AUDIO_RX_PEAK_METER_EN
  logic [c_fw-1:0] w_mag;

  // Magnitude of each channel; the most negative code saturates to max positive.
  always_comb begin
    w_mag = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (w_frame[ch*DATA_W + DATA_W - 1]) begin
        if (w_frame[ch*DATA_W +: DATA_W-1] == '0)
          w_mag[ch*DATA_W +: DATA_W] = {1'b0, {(DATA_W-1){1'b1}}};
        else
          w_mag[ch*DATA_W +: DATA_W] = -w_frame[ch*DATA_W +: DATA_W];
      end else begin
        w_mag[ch*DATA_W +: DATA_W] = w_frame[ch*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      peak_level <= '0;
    end else if (w_load) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (peak_clr || (w_mag[ch*DATA_W +: DATA_W] > peak_level[ch*DATA_W +: DATA_W]))
          peak_level[ch*DATA_W +: DATA_W] <= w_mag[ch*DATA_W +: DATA_W];
      end
    end else if (peak_clr) begin
      peak_level <= '0;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_audio_serial_rx.sv
`default_nettype none
//==============================================================================
// Module   : tb_audio_serial_rx
// Brief    : Bench for audio_serial_rx: LJ 2ch, I2S 2ch and TDM 8ch instances.
// Revision : 1.0 - initial release
//==============================================================================
module tb_audio_serial_rx;

  logic         sys_clk = 1'b0;
  logic         resetn;
  logic [2:0]   bclk_v, sync_v, sdata_v, ready_v;
  logic         clr_status;
  logic [47:0]  data0, data1;
  logic [127:0] data2;
  logic [2:0]   valid_v, ovr_v, ferr_v, lock_v;
`ifdef AUDIO_RX_PEAK_METER_EN
  logic         peak_clr;
  logic [47:0]  peak0, peak1;
  logic [127:0] peak2;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int err_cnt [3] = '{0, 0, 0};
  logic [127:0] q0[$], q1[$], q2[$];

  always #5 sys_clk = ~sys_clk;

  audio_serial_rx #(.DATA_W(24), .SLOT_W(32), .NUM_CH(2), .I2S_MODE(0)) u_lj (
    .sys_clk(sys_clk), .resetn(resetn), .bclk(bclk_v[0]), .sync(sync_v[0]),
    .sdata(sdata_v[0]), .clr_status(clr_status), .sample_data(data0),
    .sample_valid(valid_v[0]), .sample_ready(ready_v[0]), .overrun(ovr_v[0]),
    .frame_err(ferr_v[0]), .locked(lock_v[0])
`ifdef AUDIO_RX_PEAK_METER_EN
    , .peak_clr(peak_clr), .peak_level(peak0)
`endif
  );

  audio_serial_rx #(.DATA_W(24), .SLOT_W(32), .NUM_CH(2), .I2S_MODE(1)) u_i2s (
    .sys_clk(sys_clk), .resetn(resetn), .bclk(bclk_v[1]), .sync(sync_v[1]),
    .sdata(sdata_v[1]), .clr_status(clr_status), .sample_data(data1),
    .sample_valid(valid_v[1]), .sample_ready(ready_v[1]), .overrun(ovr_v[1]),
    .frame_err(ferr_v[1]), .locked(lock_v[1])
`ifdef AUDIO_RX_PEAK_METER_EN
    , .peak_clr(peak_clr), .peak_level(peak1)
`endif
  );

  audio_serial_rx #(.DATA_W(16), .SLOT_W(32), .NUM_CH(8), .I2S_MODE(0)) u_tdm (
    .sys_clk(sys_clk), .resetn(resetn), .bclk(bclk_v[2]), .sync(sync_v[2]),
    .sdata(sdata_v[2]), .clr_status(clr_status), .sample_data(data2),
    .sample_valid(valid_v[2]), .sample_ready(ready_v[2]), .overrun(ovr_v[2]),
    .frame_err(ferr_v[2]), .locked(lock_v[2])
`ifdef AUDIO_RX_PEAK_METER_EN
    , .peak_clr(peak_clr), .peak_level(peak2)
`endif
  );

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic extra_word(string name, logic [127:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: unexpected word %0h, none expected", name, act);
  endtask

  // Scoreboard: every accepted word must match the oldest expected frame.
  always @(negedge sys_clk) begin
    if (valid_v[0] && ready_v[0]) begin
      if (q0.size() == 0) extra_word("lj word", data0);
      else check("lj word", data0, q0.pop_front());
    end
    if (valid_v[1] && ready_v[1]) begin
      if (q1.size() == 0) extra_word("i2s word", data1);
      else check("i2s word", data1, q1.pop_front());
    end
    if (valid_v[2] && ready_v[2]) begin
      if (q2.size() == 0) extra_word("tdm word", data2);
      else check("tdm word", data2, q2.pop_front());
    end
    for (int d = 0; d < 3; d++)
      if (ferr_v[d]) err_cnt[d]++;
  end

  // One bclk period = 8 sys_clk; data and sync change on the falling edge.
  task automatic bit_out(int d, logic s, logic b, bit lat);
    @(posedge sys_clk); #1;
    bclk_v[d] = 1'b0; sync_v[d] = s; sdata_v[d] = b;
    repeat (4) @(posedge sys_clk);
    #1 bclk_v[d] = 1'b1;
    if (lat) begin
      @(posedge sys_clk); @(posedge sys_clk); #1;
      check("valid 2 clk after last bit", valid_v[d], 0);
      @(posedge sys_clk); #1;
      check("valid 3 clk after last bit", valid_v[d], 1);
    end else begin
      repeat (3) @(posedge sys_clk);
    end
  endtask

  task automatic idle_bits(int d, int n);
    for (int i = 0; i < n; i++) bit_out(d, (d == 1), 1'b0, 1'b0);
  endtask

  // w holds 24-bit fields, channel n in field n; I2S lead bits are driven as 1.
  task automatic send_frame(int d, logic [191:0] w, bit push, logic [127:0] exp, bit lat);
    int nch, dw, lead;
    logic s, b;
    nch  = (d == 2) ? 8 : 2;
    dw   = (d == 2) ? 16 : 24;
    lead = (d == 1) ? 1 : 0;
    if (push) begin
      case (d)
        0:       q0.push_back(exp);
        1:       q1.push_back(exp);
        default: q2.push_back(exp);
      endcase
    end
    for (int sl = 0; sl < nch; sl++) begin
      for (int k = 0; k < 32; k++) begin
        int bi;
        bi = k - lead;
        if (bi < 0)       b = 1'b1;
        else if (bi < dw) b = w[sl*24 + dw - 1 - bi];
        else              b = 1'b0;
        if (d == 2)      s = (sl == 0 && k == 0);
        else if (d == 1) s = (sl != 0);
        else             s = (sl == 0);
        bit_out(d, s, b, lat && (sl == nch - 1) && (bi == dw - 1));
      end
    end
  endtask

  typedef struct {
    int           dut;
    logic [191:0] words;
    logic [127:0] exp_word;
    logic         exp_locked;
  } vec_t;

  vec_t vecs [6];

  task automatic set_vec(int i, int d, logic [191:0] w, logic [127:0] e, logic l);
    vecs[i].dut = d; vecs[i].words = w; vecs[i].exp_word = e; vecs[i].exp_locked = l;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    logic [191:0] tdm_w;
    tdm_w = {24'h001007, 24'h001006, 24'h001005, 24'h001004,
             24'h001003, 24'h001002, 24'h001001, 24'h001000};
    set_vec(0, 0, {144'h0, 24'hFEDCBA, 24'h123456}, 128'h0000_FEDCBA_123456, 1'b0);
    set_vec(1, 0, {144'h0, 24'h800000, 24'h000001}, 128'h0000_800000_000001, 1'b1);
    set_vec(2, 1, {144'h0, 24'hFEDCBA, 24'h123456}, 128'h0000_FEDCBA_123456, 1'b0);
    set_vec(3, 1, {144'h0, 24'h7FFFFF, 24'h25A5A5}, 128'h0000_7FFFFF_25A5A5, 1'b0 | 1'b1);
    set_vec(4, 2, tdm_w, 128'h1007_1006_1005_1004_1003_1002_1001_1000, 1'b0);
    set_vec(5, 2, tdm_w, 128'h1007_1006_1005_1004_1003_1002_1001_1000, 1'b1);

    resetn = 1'b0; bclk_v = '0; sync_v = '0; sdata_v = '0; ready_v = 3'b111;
    clr_status = 1'b0;
`ifdef AUDIO_RX_PEAK_METER_EN
    peak_clr = 1'b0;
`endif
    repeat (3) @(posedge sys_clk);
    #1 resetn = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    check("reset valid", valid_v, 0);
    check("reset overrun", ovr_v, 0);
    check("reset frame_err", ferr_v, 0);
    check("reset locked", lock_v, 0);
    check("reset lj data", data0, 0);
    check("reset i2s data", data1, 0);
    check("reset tdm data", data2, 0);

    for (int i = 0; i < 6; i++) begin
      idle_bits(vecs[i].dut, 2);
      send_frame(vecs[i].dut, vecs[i].words, 1'b1, vecs[i].exp_word, i == 0);
      check($sformatf("locked after vec %0d", i), lock_v[vecs[i].dut], vecs[i].exp_locked);
    end

    // Consumer stalls across two frames: first word kept, second dropped.
    ready_v[0] = 1'b0;
    idle_bits(0, 2);
    send_frame(0, {144'h0, 24'h00ABCD, 24'h7654FF}, 1'b1, 128'h0000_00ABCD_7654FF, 1'b0);
    send_frame(0, {144'h0, 24'h111111, 24'h222222}, 1'b0, 128'h0, 1'b0);
    check("overrun set", ovr_v[0], 1);
    check("valid held", valid_v[0], 1);
    check("held data", data0, 48'h00ABCD_7654FF);
    check("locked before short", lock_v[0], 1);
    @(posedge sys_clk); #1 ready_v[0] = 1'b1;
    @(posedge sys_clk); #1;
    check("valid after handshake", valid_v[0], 0);
    check("overrun sticky", ovr_v[0], 1);
    clr_status = 1'b1;
    @(posedge sys_clk); #1 clr_status = 1'b0;
    check("overrun cleared", ovr_v[0], 0);

    // Sync restarts after 10 bits of slot 0.
    e0 = err_cnt[0];
    for (int k = 0; k < 10; k++) bit_out(0, 1'b1, k[0], 1'b0);
    bit_out(0, 1'b0, 1'b0, 1'b0);
    send_frame(0, {144'h0, 24'h0F0F0F, 24'h654321}, 1'b1, 128'h0000_0F0F0F_654321, 1'b0);
    check("frame_err pulses", err_cnt[0] - e0, 1);
    check("locked after short", lock_v[0], 0);
    send_frame(0, {144'h0, 24'h000002, 24'hFFFFFF}, 1'b1, 128'h0000_000002_FFFFFF, 1'b0);
    check("relocked", lock_v[0], 1);

`ifdef AUDIO_RX_PEAK_METER_EN
    @(posedge sys_clk); #1 peak_clr = 1'b1;
    @(posedge sys_clk); #1 peak_clr = 1'b0;
    check("peak cleared", peak0, 0);
    send_frame(0, {144'h0, 24'h000000, 24'h000100}, 1'b1, 128'h0000_000000_000100, 1'b0);
    check("peak 0x100", peak0, 48'h000000_000100);
    send_frame(0, {144'h0, 24'h000000, 24'hFFF000}, 1'b1, 128'h0000_000000_FFF000, 1'b0);
    check("peak 0x1000", peak0, 48'h000000_001000);
    send_frame(0, {144'h0, 24'h000000, 24'h800000}, 1'b1, 128'h0000_000000_800000, 1'b0);
    check("peak saturated", peak0, 48'h000000_7FFFFF);
    @(posedge sys_clk); #1 peak_clr = 1'b1;
    @(posedge sys_clk); #1 peak_clr = 1'b0;
    check("peak cleared again", peak0, 0);
`endif

    // No bclk for longer than 4 frames of sys_clk drops lock.
    repeat (300) @(posedge sys_clk);
    #1;
    check("lock lost on idle", lock_v[0], 0);
    check("lj pending words", q0.size(), 0);
    check("i2s pending words", q1.size(), 0);
    check("tdm pending words", q2.size(), 0);
    check("i2s frame_err count", err_cnt[1], 0);
    check("tdm frame_err count", err_cnt[2], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
